// File: rtl/fifo_uart_tx_if.sv
// FIFO consumer port bundle: FWFT head word, empty flag and pop strobe.
// master is the FIFO side, slave is the consumer that pops.
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_dequeue;

    modport master (
        output fifo_empty,
        output fifo_data,
        input  fifo_dequeue
    );

    modport slave (
        input  fifo_empty,
        input  fifo_data,
        output fifo_dequeue
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops words from a FWFT FIFO and shifts them out as start/data/stop frames.
// Back-to-back frames reuse the final stop cycle to pop the next word.
module fifo_uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_DIV   = 868,
    parameter int DIV_WIDTH  = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    fifo_uart_tx_if.slave fifo,
    output logic         tx,
    output logic         busy,
    output logic         tx_done
);

    localparam int IDX_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DIV_WIDTH-1:0]  cnt;
    logic [IDX_WIDTH-1:0]  idx;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  bit_end;
    logic                  last_bit;
    logic                  tx_next;
    logic                  busy_next;

    assign bit_end  = (cnt == DIV_WIDTH'(BAUD_DIV - 1));
    assign last_bit = (idx == IDX_WIDTH'(DATA_WIDTH - 1));

    // Word being serialized: load on pop, shift right after each data bit.
    always_comb begin
        shift_next = shift_reg;
        if (fifo.fifo_dequeue) begin
            shift_next = fifo.fifo_data;
        end else if (state == DATA && bit_end) begin
            shift_next = shift_reg >> 1;
        end
    end

    // State register; reset drops any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the final stop cycle can chain straight into START.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (fifo.fifo_dequeue) state_next = START;
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end && last_bit) state_next = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    state_next = fifo.fifo_dequeue ? START : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pop strobe, done pulse and the values tx/busy take at the next edge.
    always_comb begin
        fifo.fifo_dequeue = rst & enable & ~fifo.fifo_empty &
                            ((state == IDLE) ||
                             (state == STOP && bit_end));
        tx_done   = (state == STOP) && bit_end;
        tx_next   = 1'b1;
        busy_next = 1'b1;
        unique case (state_next)
            IDLE: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
            end
            START: tx_next = 1'b0;
            DATA:  tx_next = shift_next[0];
            STOP:  tx_next = 1'b1;
            default: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
            end
        endcase
    end

    // Registered line and busy flag; tx forced high the moment reset hits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx   <= 1'b1;
            busy <= 1'b0;
        end else begin
            tx   <= tx_next;
            busy <= busy_next;
        end
    end

    // Bit-period counter, bit index and shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            idx       <= '0;
            shift_reg <= '0;
        end else begin
            if (state == IDLE || bit_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_WIDTH'(1);
            end
            if (state == START) begin
                idx <= '0;
            end else if (state == DATA && bit_end) begin
                idx <= idx + IDX_WIDTH'(1);
            end
            shift_reg <= shift_next;
        end
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Consumer end of a first-word-fall-through FIFO.
- Pops one word at a time from the FIFO's dequeue/data/empty interface and serializes it as an asynchronous 8N1-style frame on a single TX line: start bit, DATA_WIDTH data bits LSB first, one stop bit.
- Sits between the FIFO instance and the UART pin in the serial peripheral.
- Supports back-to-back frames with no idle gap.

Parameters:
- DATA_WIDTH, 8, width of FIFO word and number of serial data bits.
- BAUD_DIV, 868, clk cycles per serial bit (must be >= 2).
- DIV_WIDTH, 16, width of the bit-period counter (must satisfy 2^DIV_WIDTH > BAUD_DIV).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  permits starting new frames; an in-progress frame always completes.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_WIDTH  FIFO head word; valid whenever fifo_empty=0.
- fifo_dequeue  output  1  one-cycle pop strobe to FIFO.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-cycle pulse on the last cycle of each stop bit.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE; tx=1, busy=0, tx_done=0, fifo_dequeue=0.
  - Bit-period counter and bit index cleared.
  - Reset mid-frame aborts immediately: tx returns high without waiting for a clock edge, and the already-popped word is discarded.
- States: IDLE, START, DATA, STOP.
- fifo_dequeue is combinational: enable & ~fifo_empty & (state==IDLE, or STOP on its final cycle).
  - It is never asserted while fifo_empty=1.
  - Assertion lasts exactly one cycle per frame.
- On the cycle fifo_dequeue=1, fifo_data is latched into the shift register.
  - This uses FWFT semantics: no read latency.
- IDLE:
  - tx=1, busy=0.
  - If fifo_dequeue, the next state is START and the counter is cleared.
- START:
  - tx=0 for BAUD_DIV cycles.
  - Then move to DATA with bit index 0.
- DATA:
  - tx = shift_reg[0] for BAUD_DIV cycles, then shift right and increment the bit index.
  - After bit DATA_WIDTH-1, move to STOP.
- STOP:
  - tx=1 for BAUD_DIV cycles; tx_done=1 on the final cycle.
  - On the final cycle, if fifo_dequeue, go directly to START (zero idle gap); otherwise go to IDLE.
- tx and busy are registered outputs. tx changes only on state or bit boundaries.
- Latency: the dequeue cycle is T. tx falls at the clock edge ending cycle T and is low for cycles T+1 .. T+BAUD_DIV.
- Frame length = (DATA_WIDTH+2)*BAUD_DIV cycles. Throughput is one word per frame length when the FIFO stays non-empty.
- Bit-period counter counts 0..BAUD_DIV-1 and wraps to 0 at each bit boundary.
- The bit index is wide enough to hold DATA_WIDTH-1.
- enable deasserted mid-frame: the frame finishes, then the block returns to IDLE with no pop.
- enable asserted while FIFO empty: stays in IDLE, no pop.
- fifo_empty toggling mid-frame has no effect until the next pop opportunity.
- busy=1 in START, DATA and STOP. busy stays 1 across back-to-back frames.

Test Plan (DATA_WIDTH=8, BAUD_DIV=4 unless stated):
- Reset: hold rst=0 for 3 cycles with the FIFO non-empty and enable=1 -> tx=1, busy=0, fifo_dequeue=0 throughout.
- Single frame: FIFO holds 0xA5, enable=1 -> one dequeue pulse; tx sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1; tx_done pulses at cycle 40 after the dequeue; then IDLE.
- Back-to-back: FIFO holds 0x00,0xFF -> second dequeue coincides with tx_done; no idle cycle between the stop bit and the next start bit; 80 cycles total busy.
- Empty/enable: enable=1 with FIFO empty for 50 cycles -> no dequeue, tx=1; then enable=0 with FIFO non-empty -> no dequeue.
- Enable drop mid-frame: deassert enable during DATA bit 3 with 2 words queued -> first frame completes, tx_done pulses, only 1 dequeue total.
- Reset mid-frame: assert rst asynchronously (between edges) during DATA bit 5 -> tx=1 immediately; after release, the next word is sent cleanly with a fresh start bit; BAUD_DIV=2 variant checks 20-cycle frames.
